// File: rtl/alu_exec_stage.sv
// ============================================================================
//  Module   : alu_exec_stage
//  Brief    : ALU execute stage (add/and/or/sub) with a 2-entry in-order
//             valid/ready result buffer. Optional macro ALU_EXEC_OVF_EN
//             enables signed-overflow reporting on the ovf output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    localparam int c_MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_head_res;
    logic             r_head_zero;
    logic             r_head_ovf;
    logic [WIDTH-1:0] r_tail_res;
    logic             r_tail_zero;
    logic             r_tail_ovf;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_zero;
    logic             w_push;
    logic             w_pop;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    always_comb begin
        w_sum  = op_a + op_b;
        w_diff = op_a - op_b;
        w_res  = '0;
        w_ovf  = 1'b0;
        case (alu_ctl)
            2'b00:   w_res = w_sum;
            2'b01:   w_res = op_a & op_b;
            2'b10:   w_res = op_a | op_b;
            default: w_res = w_diff;
        endcase
`ifdef ALU_EXEC_OVF_EN
        case (alu_ctl)
            2'b00:   w_ovf = (op_a[c_MSB] == op_b[c_MSB]) && (w_sum[c_MSB] != op_a[c_MSB]);
            2'b11:   w_ovf = (op_a[c_MSB] != op_b[c_MSB]) && (w_diff[c_MSB] != op_a[c_MSB]);
            default: w_ovf = 1'b0;
        endcase
`endif
        w_zero = (w_res == '0);
    end

    // Head registers are cleared whenever the buffer drains, so the outputs read 0 while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head_res  <= '0;
            r_head_zero <= 1'b0;
            r_head_ovf  <= 1'b0;
            r_tail_res  <= '0;
            r_tail_zero <= 1'b0;
            r_tail_ovf  <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_head_res  <= w_res;
                        r_head_zero <= w_zero;
                        r_head_ovf  <= w_ovf;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_head_res  <= w_res;
                        r_head_zero <= w_zero;
                        r_head_ovf  <= w_ovf;
                    end else if (w_push) begin
                        r_tail_res  <= w_res;
                        r_tail_zero <= w_zero;
                        r_tail_ovf  <= w_ovf;
                        r_state     <= TWO;
                        r_in_ready  <= 1'b0;
                    end else if (w_pop) begin
                        r_head_res  <= '0;
                        r_head_zero <= 1'b0;
                        r_head_ovf  <= 1'b0;
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_head_res  <= r_tail_res;
                        r_head_zero <= r_tail_zero;
                        r_head_ovf  <= r_tail_ovf;
                        r_tail_res  <= '0;
                        r_tail_zero <= 1'b0;
                        r_tail_ovf  <= 1'b0;
                        r_state     <= ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_head_res  <= '0;
                    r_head_zero <= 1'b0;
                    r_head_ovf  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_head_res;
    assign zero      = r_head_zero;
    assign ovf       = r_head_ovf;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// ============================================================================
//  Module   : tb_alu_exec_stage
//  Brief    : Self-checking bench for alu_exec_stage using a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_ctl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
    } ent_t;

    ent_t q[$];

    alu_exec_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

`ifdef ALU_EXEC_OVF_EN
    localparam bit c_OVF_ON = 1'b1;
`else
    localparam bit c_OVF_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on wide signed values decides overflow.
    function automatic ent_t model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        ent_t   e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        case (c)
            2'b00: begin e.res = a + b; s = sa + sb; end
            2'b01: begin e.res = a & b; s = 0; end
            2'b10: begin e.res = a | b; s = 0; end
            default: begin e.res = a - b; s = sa - sb; end
        endcase
        e.z = (e.res == 32'd0);
        e.o = c_OVF_ON && (s > 64'sd2147483647 || s < -64'sd2147483648);
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] er = 32'd0;
        logic        ez = 1'b0;
        logic        eo = 1'b0;
        if (q.size() > 0) begin
            er = q[0].res;
            ez = q[0].z;
            eo = q[0].o;
        end
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
        check({tag, ".result"},    result,         er);
        check({tag, ".zero"},      32'(zero),      32'(ez));
        check({tag, ".ovf"},       32'(ovf),       32'(eo));
    endtask

    // Called at a falling edge: drive, clock once, update model, check.
    task automatic cycle(input logic iv, input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy, input string tag);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        alu_ctl   = c;
        op_a      = a;
        op_b      = b;
        out_ready = ordy;
        do_push   = iv && (q.size() < 2);
        do_pop    = (q.size() > 0) && ordy;
        @(posedge clk);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(model(c, a, b));
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctl   = 2'b00;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b0;
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single add, one-cycle latency, then drains.
        cycle(1'b1, 2'b00, 32'd5, 32'd7, 1'b1, "add5_7");
        check("add5_7.const", result, 32'd12);
        cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, "drain1");
        check("drain1.const_valid", 32'(out_valid), 32'd0);

        cycle(1'b1, 2'b11, 32'd9, 32'd9, 1'b1, "sub9_9");
        check("sub9_9.const_zero", 32'(zero), 32'd1);
        cycle(1'b1, 2'b01, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, "and");
        check("and.const", result, 32'h00F0_00F0);
        cycle(1'b1, 2'b10, 32'h1, 32'h2, 1'b1, "or");
        check("or.const", result, 32'h3);
        cycle(1'b1, 2'b00, 32'h7FFF_FFFF, 32'h1, 1'b1, "ovf_add");
        check("ovf_add.const_res", result, 32'h8000_0000);
        check("ovf_add.const_ovf", 32'(ovf), 32'(c_OVF_ON));
        cycle(1'b1, 2'b11, 32'h8000_0000, 32'h1, 1'b1, "ovf_sub");
        check("ovf_sub.const_ovf", 32'(ovf), 32'(c_OVF_ON));
        cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, "drain2");

        // Backpressure: fill, third offer refused, then ordered drain.
        cycle(1'b1, 2'b00, 32'd100, 32'd1, 1'b0, "bp_a");
        cycle(1'b1, 2'b00, 32'd200, 32'd2, 1'b0, "bp_b");
        check("bp_b.const_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 2'b00, 32'd300, 32'd3, 1'b0, "bp_c");
        cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, "bp_pop_a");
        check("bp_pop_a.const_head", result, 32'd202);
        check("bp_pop_a.const_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, "bp_pop_b");

        // Streaming throughput from state ONE.
        cycle(1'b1, 2'b00, 32'd1000, 32'd0, 1'b1, "stream0");
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 2'b00, 32'd1000 + 32'(i), 32'd0, 1'b1, "stream");
            check("stream.const_res", result, 32'd1000 + 32'(i));
        end
        cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, "stream_end");

        // Asynchronous reset with two entries buffered.
        cycle(1'b1, 2'b10, 32'hAA, 32'h55, 1'b0, "rst_fill0");
        cycle(1'b1, 2'b10, 32'h11, 32'h22, 1'b0, "rst_fill1");
        #2 rst = 1'b1;
        #1;
        q.delete();
        check("async_rst.out_valid", 32'(out_valid), 32'd0);
        check("async_rst.in_ready",  32'(in_ready),  32'd1);
        check("async_rst.result",    result,         32'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_outputs("rst_held");
        rst = 1'b0;
        cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b1, "post_rst");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            case ($urandom_range(0, 4))
                0: b = a;
                1: b = 32'h8000_0000;
                2: b = 32'h7FFF_FFFF;
                default: b = $urandom();
            endcase
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, b,
                  $urandom_range(0, 3) != 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
